// File: rtl/vga_dac_pkg.sv
// rtl/vga_dac_pkg.sv - shared types and timing helpers for the VGA DAC matrix controller
package vga_dac_pkg;

   typedef enum logic [1:0] {
      MODE_EXT   = 2'd0,
      MODE_BARS  = 2'd1,
      MODE_RAMP  = 2'd2,
      MODE_WHITE = 2'd3
   } mode_t;

   typedef struct packed {
      logic act;
      logic hs;
      logic vs;
   } vid_ctl_t;

   localparam int LAT = 2;

   function automatic int h_total(input int act, input int fp, input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction

   function automatic int v_total(input int act, input int fp, input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - h/v raster counters with stage-0 active and sync flags
module vga_timing_gen
   import vga_dac_pkg::*;
#(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int HW       = $clog2(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP) + 1),
   parameter int VW       = $clog2(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP) + 1)
) (
   input  logic          clk,
   input  logic          rst,
   output logic [HW-1:0] h,
   output logic [VW-1:0] v,
   output vid_ctl_t      ctl
);

   localparam logic [HW-1:0] H_LAST = HW'(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST = VW'(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

   logic [HW-1:0] h_q, h_d;
   logic [VW-1:0] v_q, v_d;

   always_comb begin
      h_d = h_q + HW'(1);
      v_d = v_q;
      if (h_q == H_LAST) begin
         h_d = '0;
         v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         h_q <= '0;
         v_q <= '0;
      end else begin
         h_q <= h_d;
         v_q <= v_d;
      end
   end

   always_comb begin
      ctl.act = (h_q < H_ACT) && (v_q < V_ACT);
      ctl.hs  = (h_q >= HS_BEG) && (h_q < HS_END);
      ctl.vs  = (v_q >= VS_BEG) && (v_q < VS_END);
   end

   assign h = h_q;
   assign v = v_q;

endmodule

// File: rtl/vga_dac_matrix_ctrl.sv
// rtl/vga_dac_matrix_ctrl.sv - VGA timing, per-channel DAC code/pattern pipeline and frame-synchronous bias trim
module vga_dac_matrix_ctrl
   import vga_dac_pkg::*;
#(
   parameter int NCH      = 3,
   parameter int DW       = 8,
   parameter int BIASW    = 3,
   parameter int BIAS_RST = 4,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_en,
   input  logic                 cfg_bit,
   input  logic [NCH*DW-1:0]    pix_in,
   output logic                 pix_ready,
   output logic                 hsync,
   output logic                 vsync,
   output logic                 de,
   output logic [NCH*DW-1:0]    dac_code,
   output logic [NCH*BIASW-1:0] dac_bias
);

   localparam int HW = $clog2(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP) + 1);
   localparam int VW = $clog2(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP) + 1);
   localparam int BW = NCH * BIASW;
   localparam int SW = BW + 2;
   localparam logic [HW-1:0] BAR_W = HW'(H_ACTIVE / 8);

   logic [HW-1:0] h0;
   logic [VW-1:0] v0;
   vid_ctl_t      ctl0;

   vga_timing_gen #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .HW(HW), .VW(VW)
   ) u_timing (
      .clk (clk),
      .rst (rst),
      .h   (h0),
      .v   (v0),
      .ctl (ctl0)
   );

   logic frame_start;
   assign frame_start = (h0 == '0) && (v0 == '0);
   assign pix_ready   = ctl0.act & ~rst;

   logic              cfg_en_q, cfg_en_d;
   logic [SW-1:0]     shadow_q, shadow_d;
   logic              pending_q, pending_d;
   mode_t             mode_q, mode_d;
   logic [BW-1:0]     bias_q, bias_d;
   vid_ctl_t          ctl_q [LAT];
   vid_ctl_t          ctl_d [LAT];
   logic [HW-1:0]     h1_q, h1_d;
   logic [NCH*DW-1:0] pix1_q, pix1_d;
   logic [NCH*DW-1:0] code_q, code_d;
   logic [2:0]        bar_inv;

   // Live settings only move at frame start, using whatever the shadow holds at that moment.
   always_comb begin
      cfg_en_d  = cfg_en;
      shadow_d  = cfg_en ? {shadow_q[SW-2:0], cfg_bit} : shadow_q;
      pending_d = pending_q;
      mode_d    = mode_q;
      bias_d    = bias_q;
      if (frame_start && pending_q) begin
         mode_d    = mode_t'(shadow_q[SW-1 -: 2]);
         bias_d    = shadow_q[BW-1:0];
         pending_d = 1'b0;
      end
      if (cfg_en_q && !cfg_en) begin
         pending_d = 1'b1;
      end
   end

   always_comb begin
      ctl_d    = ctl_q;
      ctl_d[0] = ctl0;
      for (int i = 1; i < LAT; i++) begin
         ctl_d[i] = ctl_q[i-1];
      end
      h1_d    = h0;
      pix1_d  = pix_ready ? pix_in : pix1_q;
      bar_inv = ~3'(h1_q / BAR_W);
      code_d  = '0;
      case (mode_q)
         MODE_EXT:   code_d = pix1_q;
         MODE_BARS: begin
            for (int c = 0; c < NCH; c++) begin
               code_d[c*DW +: DW] = {DW{bar_inv[c % 3]}};
            end
         end
         MODE_RAMP: begin
            for (int c = 0; c < NCH; c++) begin
               code_d[c*DW +: DW] = DW'(h1_q);
            end
         end
         MODE_WHITE: code_d = '1;
         default:    code_d = '0;
      endcase
      if (!ctl_q[0].act) begin
         code_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_en_q  <= 1'b0;
         shadow_q  <= '0;
         pending_q <= 1'b0;
         mode_q    <= MODE_EXT;
         bias_q    <= {NCH{BIASW'(BIAS_RST)}};
         for (int i = 0; i < LAT; i++) begin
            ctl_q[i] <= '0;
         end
         h1_q   <= '0;
         pix1_q <= '0;
         code_q <= '0;
      end else begin
         cfg_en_q  <= cfg_en_d;
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
         mode_q    <= mode_d;
         bias_q    <= bias_d;
         for (int i = 0; i < LAT; i++) begin
            ctl_q[i] <= ctl_d[i];
         end
         h1_q   <= h1_d;
         pix1_q <= pix1_d;
         code_q <= code_d;
      end
   end

   assign hsync    = ctl_q[LAT-1].hs ? SYNC_POL : ~SYNC_POL;
   assign vsync    = ctl_q[LAT-1].vs ? SYNC_POL : ~SYNC_POL;
   assign de       = ctl_q[LAT-1].act;
   assign dac_code = code_q;
   assign dac_bias = bias_q;

endmodule

// File: tb/tb_vga_dac_matrix_ctrl.sv
// tb/tb_vga_dac_matrix_ctrl.sv - randomized bench for vga_dac_matrix_ctrl against a raster-level reference model
module tb_vga_dac_matrix_ctrl;

   localparam int NCH = 4, DW = 6, BIASW = 3, BIAS_RST = 4;
   localparam int HA = 96, HFP = 4, HS = 8, HBP = 4;
   localparam int VA = 8, VFP = 1, VS = 2, VBP = 1;
   localparam bit SP = 1'b1;
   localparam int HT = HA + HFP + HS + HBP;
   localparam int VT = VA + VFP + VS + VBP;
   localparam int SW = NCH * BIASW + 2;
   localparam int PW = 3 + NCH * DW;
   localparam logic [PW-1:0] IDLE = {~SP, ~SP, 1'b0, {(NCH*DW){1'b0}}};

   logic                 clk = 1'b0;
   logic                 rst, cfg_en, cfg_bit, pix_ready, hsync, vsync, de;
   logic [NCH*DW-1:0]    pix_in, dac_code;
   logic [NCH*BIASW-1:0] dac_bias;

   vga_dac_matrix_ctrl #(
      .NCH(NCH), .DW(DW), .BIASW(BIASW), .BIAS_RST(BIAS_RST),
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .SYNC_POL(SP)
   ) dut (
      .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_bit(cfg_bit),
      .pix_in(pix_in), .pix_ready(pix_ready),
      .hsync(hsync), .vsync(vsync), .de(de),
      .dac_code(dac_code), .dac_bias(dac_bias)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   int m_h, m_v, m_frame, m_mode;
   int m_bias [NCH];
   bit m_shadow [$];
   bit m_pending, m_cfg_prev;
   logic [PW-1:0] cur, nxt;
   bit cfg_q [$];

   function automatic logic [PW-1:0] pix_word(input int h, input int v, input int mode,
                                              input logic [NCH*DW-1:0] pin);
      bit act, hs, vs;
      int val;
      logic [NCH*DW-1:0] code;
      act  = (h < HA) && (v < VA);
      hs   = (h >= HA + HFP) && (h < HA + HFP + HS);
      vs   = (v >= VA + VFP) && (v < VA + VFP + VS);
      code = '0;
      if (act) begin
         for (int c = 0; c < NCH; c++) begin
            case (mode)
               0:       val = int'(pin[c*DW +: DW]);
               1:       val = (((7 - h / (HA / 8)) >> (c % 3)) & 1) ? (1 << DW) - 1 : 0;
               2:       val = h % (1 << DW);
               default: val = (1 << DW) - 1;
            endcase
            code[c*DW +: DW] = DW'(val);
         end
      end
      return {(hs ? SP : ~SP), (vs ? SP : ~SP), act, code};
   endfunction

   function automatic logic [NCH*BIASW-1:0] bias_vec();
      logic [NCH*BIASW-1:0] r;
      for (int k = 0; k < NCH; k++) r[k*BIASW +: BIASW] = BIASW'(m_bias[k]);
      return r;
   endfunction

   task automatic model_reset();
      m_h = 0; m_v = 0; m_mode = 0; m_pending = 0; m_cfg_prev = 0;
      for (int k = 0; k < NCH; k++) m_bias[k] = BIAS_RST;
      m_shadow.delete();
      for (int i = 0; i < SW; i++) m_shadow.push_back(1'b0);
      cur = IDLE; nxt = IDLE;
   endtask

   task automatic model_step();
      bit fs, fall;
      int val;
      if (rst) begin
         model_reset();
         return;
      end
      fs   = (m_h == 0) && (m_v == 0);
      fall = m_cfg_prev && !cfg_en;
      if (fs && m_pending) begin
         m_mode = 2 * m_shadow[0] + m_shadow[1];
         for (int k = 0; k < NCH; k++) begin
            val = 0;
            for (int j = 0; j < BIASW; j++) val = 2 * val + m_shadow[2 + (NCH - 1 - k) * BIASW + j];
            m_bias[k] = val;
         end
         m_pending = 0;
      end
      if (fall) m_pending = 1;
      if (cfg_en) begin
         m_shadow.push_back(cfg_bit);
         void'(m_shadow.pop_front());
      end
      m_cfg_prev = cfg_en;
      cur = nxt;
      nxt = pix_word(m_h, m_v, m_mode, pix_in);
      m_h++;
      if (m_h == HT) begin
         m_h = 0;
         m_v++;
         if (m_v == VT) begin
            m_v = 0;
            m_frame++;
         end
      end
   endtask

   task automatic push_bits(input logic [31:0] bits, input int len);
      for (int i = len - 1; i >= 0; i--) cfg_q.push_back(bits[i]);
   endtask

   initial begin
      int n, rst_left, len;
      bit rst_done;
      rst = 1'b1; cfg_en = 1'b0; cfg_bit = 1'b0; pix_in = '0;
      m_frame = 0; rst_left = 0; rst_done = 0; n = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      while (m_frame < 8 && n < 20000) begin
         if (!rst_done && m_frame == 1 && m_v == 2 && m_h == 30) begin
            rst_left = 3;
            rst_done = 1;
         end
         rst = (rst_left > 0);
         if (rst_left > 0) rst_left--;
         if (cfg_q.size() == 0 && !rst) begin
            if (m_frame == 2 && m_v == 3 && m_h == 20)
               push_bits(32'b01_001_101_010_111, SW);
            else if (m_frame == 4 && m_v == VT - 1 && m_h == HT - SW)
               push_bits(32'b10_011_011_011_011, SW);
            else if ((m_frame < 2 || m_frame > 6) && m_v < VA - 2 && $urandom_range(0, 199) == 0) begin
               len = $urandom_range(6, 20);
               push_bits($urandom, len);
            end
         end
         if (cfg_q.size() != 0) begin
            cfg_en  = 1'b1;
            cfg_bit = cfg_q.pop_front();
         end else begin
            cfg_en  = 1'b0;
            cfg_bit = 1'($urandom);
         end
         pix_in = (NCH*DW)'($urandom);
         #1;
         check_eq("pix_ready", 64'(pix_ready), 64'(!rst && m_h < HA && m_v < VA));
         check_eq("outputs", 64'({hsync, vsync, de, dac_code, dac_bias}), 64'({cur, bias_vec()}));
         if (m_v == 1 && m_h == 8 && m_frame == 3) begin
            check_eq("bars_bias", 64'(dac_bias), 64'h357);
            check_eq("bars_white", 64'(dac_code), 64'hFFFFFF);
         end
         if (m_v == 1 && m_h == 17 && m_frame == 3) check_eq("bars_bar1", 64'(dac_code), 64'h03FFC0);
         if (m_v == 1 && m_h == 92 && m_frame == 3) check_eq("bars_black", 64'(dac_code), 64'h0);
         if (m_v == 1 && m_h == 72 && m_frame == 5) begin
            check_eq("edge_bias_held", 64'(dac_bias), 64'h357);
            check_eq("edge_bars_bar5", 64'(dac_code), 64'h000FC0);
         end
         if (m_v == 1 && m_h == 72 && m_frame == 6) begin
            check_eq("ramp_bias", 64'(dac_bias), 64'h6DB);
            check_eq("ramp_code", 64'(dac_code), 64'h186186);
         end
         model_step();
         @(posedge clk);
         #1;
         n++;
      end
      check_eq("run_bound", 64'(m_frame >= 8), 64'd1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
